// File: rtl/hazard_monitor.sv
// Glitch classifier for a single asynchronous net: synchronizes, filters to a stable level,
// and reports sub-MIN_WIDTH excursions as static-1/static-0 hazards. Optional macro: HAZ_TIMESTAMP_EN.
module hazard_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 4,
   parameter int WID_W       = 4,
   parameter int CNT_W       = 8,
   parameter int TS_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             clr,
   output logic             stable_out,
   output logic             evt_valid,
   output logic             evt_type,
   output logic [WID_W-1:0] evt_width,
   output logic [CNT_W-1:0] haz1_cnt,
   output logic [CNT_W-1:0] haz0_cnt,
   output logic             sticky_err,
   output logic [TS_W-1:0]  evt_ts
);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_PULSE  = 1'b1
   } state_t;

   localparam logic [WID_W-1:0] RUN_ONE  = WID_W'(1);
   localparam logic [WID_W-1:0] RUN_LAST = WID_W'(MIN_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s;
   state_t                 state_q, state_d;
   logic                   level_q, level_d;
   logic [WID_W-1:0]       run_q, run_d;
   logic                   evt_valid_q, evt_valid_d;
   logic                   evt_type_q, evt_type_d;
   logic [WID_W-1:0]       evt_width_q, evt_width_d;
   logic [CNT_W-1:0]       haz1_q, haz1_d;
   logic [CNT_W-1:0]       haz0_q, haz0_d;
   logic                   sticky_q, sticky_d;
   logic                   glitch;

   assign s      = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};

   // A glitch is a return to the accepted level before the deviation was long enough to be accepted.
   assign glitch = (state_q == ST_PULSE) && (s == level_q);

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      run_d       = run_q;
      evt_valid_d = 1'b0;
      evt_type_d  = evt_type_q;
      evt_width_d = evt_width_q;
      case (state_q)
         ST_STABLE: begin
            if (s != level_q) begin
               state_d = ST_PULSE;
               run_d   = RUN_ONE;
            end
         end
         ST_PULSE: begin
            if (s != level_q) begin
               if (run_q == RUN_LAST) begin
                  level_d = s;
                  state_d = ST_STABLE;
                  run_d   = '0;
               end else begin
                  run_d = run_q + RUN_ONE;
               end
            end else begin
               evt_valid_d = 1'b1;
               evt_type_d  = level_q;
               evt_width_d = run_q;
               state_d     = ST_STABLE;
               run_d       = '0;
            end
         end
         default: begin
            state_d = ST_STABLE;
            run_d   = '0;
         end
      endcase
   end

   // Clear takes priority over a coincident increment; the event strobe itself is unaffected.
   always_comb begin
      haz1_d   = haz1_q;
      haz0_d   = haz0_q;
      sticky_d = sticky_q | glitch;
      if (clr) begin
         haz1_d   = '0;
         haz0_d   = '0;
         sticky_d = 1'b0;
      end else if (glitch) begin
         if (level_q && (haz1_q != CNT_MAX)) begin
            haz1_d = haz1_q + CNT_ONE;
         end
         if (!level_q && (haz0_q != CNT_MAX)) begin
            haz0_d = haz0_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         state_q     <= ST_STABLE;
         level_q     <= 1'b0;
         run_q       <= '0;
         evt_valid_q <= 1'b0;
         evt_type_q  <= 1'b0;
         evt_width_q <= '0;
         haz1_q      <= '0;
         haz0_q      <= '0;
         sticky_q    <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         level_q     <= level_d;
         run_q       <= run_d;
         evt_valid_q <= evt_valid_d;
         evt_type_q  <= evt_type_d;
         evt_width_q <= evt_width_d;
         haz1_q      <= haz1_d;
         haz0_q      <= haz0_d;
         sticky_q    <= sticky_d;
      end
   end

   assign stable_out = level_q;
   assign evt_valid  = evt_valid_q;
   assign evt_type   = evt_type_q;
   assign evt_width  = evt_width_q;
   assign haz1_cnt   = haz1_q;
   assign haz0_cnt   = haz0_q;
   assign sticky_err = sticky_q;

`ifdef HAZ_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q, ts_d;
   logic [TS_W-1:0] evt_ts_q, evt_ts_d;

   always_comb begin
      ts_d     = ts_q + TS_W'(1);
      evt_ts_d = evt_ts_q;
      if (glitch) begin
         evt_ts_d = ts_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q     <= '0;
         evt_ts_q <= '0;
      end else begin
         ts_q     <= ts_d;
         evt_ts_q <= evt_ts_d;
      end
   end

   assign evt_ts = evt_ts_q;
`else
   assign evt_ts = '0;
`endif

endmodule
